calc_mem_responder: RTL

//  Memory-side responder for the calculator controller's read/write port. Owns DEPTH words of
//  MEM_WORD_SIZE-bit storage, serves reads with READ_LAT-cycle registered latency, commits

---
 rtl/calc_mem_responder.sv | 102 ++++++++++
 1 files changed

// File: rtl/calc_mem_responder.sv
// Storage responder for the calculator controller's port: zero-fills after reset,
// serves pipelined fixed-latency reads, one-cycle writes and flags illegal accesses.
module calc_mem_responder #(
  parameter int ADDR_W        = 9,
  parameter int MEM_WORD_SIZE = 64,
  parameter int DEPTH         = 512,
  parameter int READ_LAT      = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     read,
  input  logic [ADDR_W-1:0]        r_addr,
  output logic [MEM_WORD_SIZE-1:0] r_data,
  output logic                     r_valid,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [MEM_WORD_SIZE-1:0] w_data,
  output logic                     init_busy,
  output logic                     err,
  input  logic                     err_clr
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         fill_ptr;
  logic [MEM_WORD_SIZE-1:0] mem [DEPTH];

  logic                     ready, rd_ok, wr_ok, rd_fire, wr_fire, err_set;
  logic [IDX_W-1:0]         r_idx, w_idx;
  logic [MEM_WORD_SIZE-1:0] rd_word;

  // Stage k is loaded k-1 edges after acceptance; the last stage is the output.
  logic [READ_LAT:1]                    vld_pipe;
  logic [READ_LAT:1][MEM_WORD_SIZE-1:0] dat_pipe;
  logic [READ_LAT:0]                    vin;
  logic [READ_LAT:0][MEM_WORD_SIZE-1:0] din;

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && fill_ptr == LAST) state_d = S_READY;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_INIT;
      fill_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) fill_ptr <= fill_ptr + 1'b1;
    end
  end

  assign ready     = (state_q == S_READY);
  assign init_busy = (state_q == S_INIT);
  assign rd_ok     = ({1'b0, r_addr} < DEPTH_X);
  assign wr_ok     = ({1'b0, w_addr} < DEPTH_X);
  assign rd_fire   = ready && read  && rd_ok;
  assign wr_fire   = ready && write && wr_ok;
  assign r_idx     = r_addr[IDX_W-1:0];
  assign w_idx     = w_addr[IDX_W-1:0];
  assign err_set   = (!ready && (read || write)) ||
                     (ready && ((read && !rd_ok) || (write && !wr_ok)));

  // Same-cycle write to the read address is forwarded (write-first).
  assign rd_word = (wr_fire && w_addr == r_addr) ? w_data : mem[r_idx];

  always_ff @(posedge clk_i) begin
    if (state_q == S_INIT) mem[fill_ptr] <= '0;
    else if (wr_fire)      mem[w_idx]    <= w_data;
  end

  assign vin = {vld_pipe, rd_fire};
  assign din = {dat_pipe, rd_word};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      for (int k = 1; k <= READ_LAT; k++) begin
        vld_pipe[k] <= vin[k-1];
        // Output stage only moves on a valid word so r_data holds between pulses.
        if (vin[k-1] || k < READ_LAT) dat_pipe[k] <= din[k-1];
      end
    end
  end

  assign r_valid = vld_pipe[READ_LAT];
  assign r_data  = dat_pipe[READ_LAT];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

endmodule
